// File: rtl/ped_walk_controller.sv
// Pedestrian walk-phase controller downstream of the vehicle light controller.
// Latches a request, grants Walk at a red rising edge, then runs a flashing countdown.
module ped_walk_controller #(
  parameter int WALK_CYCLES  = 8,
  parameter int FLASH_CYCLES = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Red,
  input  logic       Green,
  input  logic       Yellow,
  input  logic       ped_button,
  output logic       Walk,
  output logic       DontWalk,
  output logic       ped_waiting,
  output logic [3:0] countdown,
  output logic       fault
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WALK  = 2'd1;
  localparam logic [1:0] FLASH = 2'd2;

  localparam logic [3:0] WC = 4'(WALK_CYCLES);
  localparam logic [3:0] FC = 4'(FLASH_CYCLES);

  logic [1:0] state;
  logic [3:0] wcnt;
  logic       red_q;
  logic       red_rise;
  logic       valid;

  assign red_rise = Red & ~red_q;
  assign valid    = (Red & ~Green & ~Yellow) | (~Red & Green & ~Yellow) |
                    (~Red & ~Green & Yellow);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wcnt        <= '0;
      red_q       <= 1'b0;
      Walk        <= 1'b0;
      DontWalk    <= 1'b1;
      ped_waiting <= 1'b0;
      countdown   <= '0;
      fault       <= 1'b0;
    end else begin
      red_q <= Red;
      fault <= ~valid;
      // Invalid light inputs force safe outputs; a pending request is held.
      if (!valid) begin
        state     <= IDLE;
        Walk      <= 1'b0;
        DontWalk  <= 1'b1;
        countdown <= '0;
      end else begin
        case (state)
          IDLE: begin
            Walk      <= 1'b0;
            DontWalk  <= 1'b1;
            countdown <= '0;
            if (ped_waiting && red_rise) begin
              // Clear wins over a simultaneous press: the grant serves it.
              state       <= WALK;
              Walk        <= 1'b1;
              DontWalk    <= 1'b0;
              wcnt        <= WC;
              ped_waiting <= 1'b0;
            end else if (ped_button) begin
              ped_waiting <= 1'b1;
            end
          end
          WALK: begin
            if (!Red) begin
              state    <= IDLE;
              Walk     <= 1'b0;
              DontWalk <= 1'b1;
            end else if (wcnt == 4'd1) begin
              state     <= FLASH;
              Walk      <= 1'b0;
              DontWalk  <= 1'b1;
              countdown <= FC;
            end else begin
              wcnt <= wcnt - 4'd1;
            end
          end
          FLASH: begin
            if (!Red) begin
              state     <= IDLE;
              DontWalk  <= 1'b1;
              countdown <= '0;
            end else begin
              if (ped_button) ped_waiting <= 1'b1;
              if (countdown == 4'd1) begin
                state     <= IDLE;
                DontWalk  <= 1'b1;
                countdown <= '0;
              end else begin
                countdown <= countdown - 4'd1;
                DontWalk  <= ~DontWalk;
              end
            end
          end
          default: begin
            state     <= IDLE;
            Walk      <= 1'b0;
            DontWalk  <= 1'b1;
            countdown <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ped_walk_controller.sv
// Directed bench for ped_walk_controller with WALK_CYCLES=4, FLASH_CYCLES=4.
module tb_ped_walk_controller;
  logic       clk = 1'b0;
  logic       reset, Red, Green, Yellow, ped_button;
  logic       Walk, DontWalk, ped_waiting, fault;
  logic [3:0] countdown;
  int         total = 0;
  int         passed = 0;

  ped_walk_controller #(.WALK_CYCLES(4), .FLASH_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .Red(Red), .Green(Green), .Yellow(Yellow),
    .ped_button(ped_button), .Walk(Walk), .DontWalk(DontWalk),
    .ped_waiting(ped_waiting), .countdown(countdown), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic w, input logic dw,
                         input logic pw, input logic [3:0] cd, input logic f);
    chk({tag, ".Walk"}, {3'b0, Walk}, {3'b0, w});
    chk({tag, ".DontWalk"}, {3'b0, DontWalk}, {3'b0, dw});
    chk({tag, ".ped_waiting"}, {3'b0, ped_waiting}, {3'b0, pw});
    chk({tag, ".countdown"}, countdown, cd);
    chk({tag, ".fault"}, {3'b0, fault}, {3'b0, f});
  endtask

  initial begin
    reset = 1; Red = 1; Green = 0; Yellow = 0; ped_button = 0;
    cyc(); cyc();
    chk_out("reset", 0, 1, 0, 0, 0);

    // Normal service
    reset = 0; Red = 0; Green = 1;
    cyc();
    ped_button = 1; cyc(); ped_button = 0;
    chk_out("press", 0, 1, 1, 0, 0);
    Red = 1; Green = 0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk_out("walk", 1, 0, 0, 0, 0);
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      chk_out("flash", 0, (i % 2 == 0), 0, 4'(4 - i), 0);
      cyc();
    end
    chk_out("idle_after", 0, 1, 0, 0, 0);

    // Late press while red already high
    ped_button = 1; cyc(); ped_button = 0;
    chk_out("late_press", 0, 1, 1, 0, 0);
    cyc(); cyc();
    chk_out("late_no_walk", 0, 1, 1, 0, 0);
    Red = 0; Yellow = 1; cyc();
    Yellow = 0; Green = 1; cyc();
    chk_out("late_green", 0, 1, 1, 0, 0);
    Green = 0; Red = 1; cyc();
    chk_out("late_grant", 1, 0, 0, 0, 0);

    // Early red end in 2nd walk cycle
    cyc();
    chk_out("early_walk2", 1, 0, 0, 0, 0);
    Red = 0; Green = 1; cyc();
    chk_out("early_abort", 0, 1, 0, 0, 0);
    cyc();
    chk_out("early_stay", 0, 1, 0, 0, 0);

    // Fault during WALK, plus press during WALK ignored
    ped_button = 1; cyc(); ped_button = 0;
    Green = 0; Red = 1; cyc();
    chk_out("f_grant", 1, 0, 0, 0, 0);
    ped_button = 1; cyc(); ped_button = 0;
    chk_out("walk_press", 1, 0, 0, 0, 0);
    Green = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_out("fault", 0, 1, 0, 0, 1);
    end
    Green = 0; cyc();
    chk_out("fault_clear", 0, 1, 0, 0, 0);

    // Press during FLASH, then simultaneous press and grant
    Red = 0; Green = 1; cyc();
    ped_button = 1; cyc(); ped_button = 0;
    Green = 0; Red = 1; cyc();
    chk_out("p_grant", 1, 0, 0, 0, 0);
    cyc(); cyc(); cyc(); cyc();
    chk_out("p_flash1", 0, 1, 0, 4, 0);
    ped_button = 1; cyc(); ped_button = 0;
    chk_out("p_flash_press", 0, 0, 1, 3, 0);
    cyc(); cyc(); cyc();
    chk_out("p_idle", 0, 1, 1, 0, 0);
    Red = 0; Green = 1; cyc();
    Green = 0; Red = 1; ped_button = 1; cyc(); ped_button = 0;
    chk_out("simul_grant", 1, 0, 0, 0, 0);

    // Reset mid-phase
    reset = 1; cyc(); reset = 0;
    chk_out("reset_mid", 0, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
